// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order write-back buffer in front of the 32-entry
// register bank. Accepts write requests over a valid/ready handshake and
// drains them into the bank's single write port, one per cycle. Pending
// entries are forwarded to the two read ports so that readers never see
// stale bank contents.
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   WB_VALID/ADDR/DATA    producer write request
//   WB_READY              request can be accepted (queue not full)
//   HOLD                  pause draining (bank port borrowed externally)
//   REG_WRITE/AW/DIN      bank write port, driven from the queue head
//   AR1/AR2               bank read addresses, also used for forwarding
//   FWDx_HIT/FWDx_DATA    newest pending data matching ARx
//   COUNT, EMPTY          occupancy
module reg_writeback_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW_BITS = 5,
    parameter int unsigned DW      = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       WB_VALID,
    input  logic [AW_BITS-1:0]         WB_ADDR,
    input  logic [DW-1:0]              WB_DATA,
    output logic                       WB_READY,
    input  logic                       HOLD,
    output logic                       REG_WRITE,
    output logic [AW_BITS-1:0]         AW,
    output logic [DW-1:0]              DIN,
    input  logic [AW_BITS-1:0]         AR1,
    input  logic [AW_BITS-1:0]         AR2,
    output logic                       FWD1_HIT,
    output logic [DW-1:0]              FWD1_DATA,
    output logic                       FWD2_HIT,
    output logic [DW-1:0]              FWD2_DATA,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       EMPTY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [AW_BITS-1:0] addr_q [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake and drain decisions; ready depends on state only.
    always_comb begin
        full  = (cnt_q == CNT_W'(DEPTH));
        empty = (cnt_q == '0);
        // Register 0 is never written: handshake completes, nothing is stored.
        push  = WB_VALID && !full && (WB_ADDR != '0);
        pop   = !empty && !HOLD;
    end

    // Next-state for pointers, occupancy and valid bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        // Push slot never equals the pop slot: full blocks push, empty blocks pop.
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state with synchronous reset; reset discards in-flight entries.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage; contents are qualified by valid_q so no reset needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr_q] <= WB_ADDR;
            data_q[wr_ptr_q] <= WB_DATA;
        end
    end

    // Forwarding: scan oldest to newest so the newest match overrides.
    logic [PTR_W-1:0] scan_idx;
    always_comb begin
        FWD1_HIT  = 1'b0;
        FWD1_DATA = '0;
        FWD2_HIT  = 1'b0;
        FWD2_DATA = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PTR_W'(k);
            if (valid_q[scan_idx]) begin
                if ((AR1 != '0) && (addr_q[scan_idx] == AR1)) begin
                    FWD1_HIT  = 1'b1;
                    FWD1_DATA = data_q[scan_idx];
                end
                if ((AR2 != '0) && (addr_q[scan_idx] == AR2)) begin
                    FWD2_HIT  = 1'b1;
                    FWD2_DATA = data_q[scan_idx];
                end
            end
        end
    end

    // Bank write port and status; head is gated to zero when empty.
    always_comb begin
        WB_READY  = !full;
        REG_WRITE = pop;
        AW        = empty ? '0 : addr_q[rd_ptr_q];
        DIN       = empty ? '0 : data_q[rd_ptr_q];
        COUNT     = cnt_q;
        EMPTY     = empty;
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: the driver pushes the expected
// bank writes into a queue on acceptance, a negedge monitor pops and
// compares whenever REG_WRITE is presented. Directed checks cover the
// handshake, forwarding and reset corner cases.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        hold;
    logic        reg_write;
    logic [4:0]  aw;
    logic [31:0] din;
    logic [4:0]  ar1;
    logic [4:0]  ar2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  count;
    logic        empty;

    reg_writeback_queue #(.DEPTH(DEPTH), .AW_BITS(5), .DW(32)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .WB_VALID  (wb_valid),
        .WB_ADDR   (wb_addr),
        .WB_DATA   (wb_data),
        .WB_READY  (wb_ready),
        .HOLD      (hold),
        .REG_WRITE (reg_write),
        .AW        (aw),
        .DIN       (din),
        .AR1       (ar1),
        .AR2       (ar2),
        .FWD1_HIT  (fwd1_hit),
        .FWD1_DATA (fwd1_data),
        .FWD2_HIT  (fwd2_hit),
        .FWD2_DATA (fwd2_data),
        .COUNT     (count),
        .EMPTY     (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            checks = 0;
    int            errors = 0;
    int            exp_cnt = 0;
    logic [36:0]   exp_q[$];
    logic [31:0]   bank [32];
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge plus the reference model update for that edge.
    task automatic tick();
        bit acc;
        bit pp;
        @(posedge clk);
        if (!rst_n) begin
            exp_cnt = 0;
            exp_q.delete();
        end else begin
            pp  = (exp_cnt != 0) && !hold;
            acc = wb_valid && (exp_cnt != DEPTH) && (wb_addr != 5'd0);
            if (acc) exp_q.push_back({wb_addr, wb_data});
            exp_cnt = exp_cnt + int'(acc) - int'(pp);
        end
        #1;
    endtask

    task automatic push_one(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    // Monitor: status against the model, bank writes against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_count", 32'(count), 32'(exp_cnt));
            chk("mon_ready", 32'(wb_ready), 32'(exp_cnt != DEPTH));
            chk("mon_regwrite", 32'(reg_write), 32'((exp_cnt != 0) && !hold));
            if (reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_write: got aw=%0d din=0x%0h expected no write", aw, din);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("mon_aw", 32'(aw), 32'(e[36:32]));
                    chk("mon_din", din, e[31:0]);
                end
                bank[aw] = din;
            end
        end
    end

    initial begin
        logic [4:0] aw_seq [4];
        int n;
        aw_seq[0] = 5'd3; aw_seq[1] = 5'd3; aw_seq[2] = 5'd7; aw_seq[3] = 5'd9;
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        hold = 1'b0; ar1 = 5'd5; ar2 = 5'd0;

        // Reset then idle
        tick(); tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_regwrite", 32'(reg_write), 32'd0);
        chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("rst_fwd1_data", fwd1_data, 32'd0);
        chk("rst_aw", 32'(aw), 32'd0);
        tick();

        // Single push, earliest drain
        push_one(5'd5, 32'h11);
        ar1 = 5'd5;
        #1;
        chk("lat_regwrite", 32'(reg_write), 32'd1);
        chk("lat_aw", 32'(aw), 32'd5);
        chk("lat_din", din, 32'h11);
        chk("lat_fwd1_hit", 32'(fwd1_hit), 32'd1);
        chk("lat_fwd1_data", fwd1_data, 32'h11);
        tick();
        #1;
        chk("lat_empty", 32'(empty), 32'd1);

        // HOLD, fill, reject fifth, forward newest, ordered drain
        hold = 1'b1;
        push_one(5'd3, 32'hA);
        push_one(5'd3, 32'hB);
        push_one(5'd7, 32'hC);
        push_one(5'd9, 32'hD);
        wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'hE;
        ar1 = 5'd3; ar2 = 5'd7;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(wb_ready), 32'd0);
        chk("full_fwd1_data", fwd1_data, 32'hB);
        chk("full_fwd2_data", fwd2_data, 32'hC);
        ar2 = 5'd9;
        #1;
        chk("full_fwd2_hit9", 32'(fwd2_hit), 32'd1);
        chk("full_fwd2_data9", fwd2_data, 32'hD);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("full_reject_count", 32'(count), 32'd4);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_aw", 32'(aw), 32'(aw_seq[i]));
            tick();
        end
        #1;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("bank_r3", bank[3], 32'hB);
        chk("bank_r11", bank[11], 32'h0);

        // Full with WB_VALID held: pop-only cycle, then push-only cycle
        hold = 1'b1;
        push_one(5'd1, 32'h21);
        push_one(5'd2, 32'h22);
        push_one(5'd4, 32'h24);
        push_one(5'd6, 32'h26);
        wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h28;
        hold = 1'b0;
        #1;
        chk("fp_count0", 32'(count), 32'd4);
        chk("fp_ready0", 32'(wb_ready), 32'd0);
        tick();
        hold = 1'b1;
        #1;
        chk("fp_count1", 32'(count), 32'd3);
        chk("fp_ready1", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("fp_count2", 32'(count), 32'd4);
        hold = 1'b0;
        n = 0;
        while (exp_cnt != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("fp_drain_done", 32'(count), 32'd0);
        chk("bank_r8", bank[8], 32'h28);

        // Register 0: handshake only
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
        #1;
        chk("r0_ready", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        ar1 = 5'd0;
        #1;
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_regwrite", 32'(reg_write), 32'd0);
        chk("r0_fwd1_hit", 32'(fwd1_hit), 32'd0);
        tick();

        // Single entry: simultaneous push and pop
        push_one(5'd10, 32'hA1);
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hA2;
        #1;
        chk("pp_din0", din, 32'hA1);
        chk("pp_regwrite0", 32'(reg_write), 32'd1);
        tick();
        wb_valid = 1'b0;
        ar1 = 5'd10;
        #1;
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_din1", din, 32'hA2);
        chk("pp_fwd1_data", fwd1_data, 32'hA2);
        tick();
        #1;
        chk("pp_bank", bank[10], 32'hA2);

        // Reset with entries in flight and a push pending
        hold = 1'b1;
        push_one(5'd13, 32'h31);
        push_one(5'd14, 32'h32);
        push_one(5'd15, 32'h33);
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h34;
        rst_n = 1'b0;
        #1;
        chk("rs_count_pre", 32'(count), 32'd3);
        tick();
        rst_n = 1'b1; wb_valid = 1'b0; hold = 1'b0; ar1 = 5'd13; ar2 = 5'd12;
        #1;
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_empty", 32'(empty), 32'd1);
        chk("rs_regwrite", 32'(reg_write), 32'd0);
        chk("rs_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("rs_fwd2_hit", 32'(fwd2_hit), 32'd0);
        tick();
        #1;
        chk("rs_regwrite2", 32'(reg_write), 32'd0);
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
Write-side front end for the 32x32 register bank. Result producers (ALU, load unit) push register write requests through a valid/ready handshake. Requests are buffered in a small in-order FIFO and drained into the bank's write port (REG_WRITE/AW/DIN) at one per cycle. Read addresses AR1/AR2 are compared against pending entries, and the newest pending data is forwarded so readers never see stale bank contents.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2
AW_BITS, 5, register address width
DW, 32, register data width

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST_N  input  1  synchronous, active-low reset
WB_VALID  input  1  producer has a write request
WB_ADDR  input  AW_BITS  destination register
WB_DATA  input  DW  write data
WB_READY  output  1  queue can accept; equals not full
HOLD  input  1  when 1, draining pauses (bank port in use by external loader)
REG_WRITE  output  1  write strobe to bank
AW  output  AW_BITS  bank write address
DIN  output  DW  bank write data
AR1  input  AW_BITS  read address 1 (same value driven to bank)
AR2  input  AW_BITS  read address 2
FWD1_HIT  output  1  AR1 matches a pending entry
FWD1_DATA  output  DW  newest pending data for AR1; 0 when no hit
FWD2_HIT  output  1  AR2 matches a pending entry
FWD2_DATA  output  DW  newest pending data for AR2; 0 when no hit
COUNT  output  clog2(DEPTH)+1  number of occupied entries
EMPTY  output  1  COUNT == 0

Behaviour:
- Storage: circular buffer with DEPTH entries {addr, data, valid}, plus a write pointer, read pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Reset (RST_N=0 at a clock edge): pointers cleared, COUNT=0, all valid bits cleared, EMPTY=1, WB_READY=1, REG_WRITE=0. AW and DIN read 0 when empty. FWD*_HIT=0 and FWD*_DATA=0. Reset overrides any push or pop in the same cycle, and all in-flight entries are discarded.
- Push: when WB_VALID & WB_READY at the edge, the entry is written at the write pointer and the write pointer advances.
  - Exception: WB_ADDR==0 completes the handshake but does not enqueue, because register 0 is never written.
- WB_READY = (COUNT != DEPTH). It is combinational from state only, never from WB_VALID. When full, no push is accepted, even in a cycle that pops.
- Drain: REG_WRITE = !EMPTY & !HOLD. AW and DIN show the head entry combinationally. When REG_WRITE=1, the head is popped at that edge.
- HOLD=1: REG_WRITE=0 and the head stays put. Pushes are still accepted until the queue is full.
- Latency: a request accepted at edge N is presented on REG_WRITE in cycle N+1 at the earliest, when the queue was empty and HOLD=0. It is written to the bank at edge N+1.
- Simultaneous push and pop (not full): both happen and COUNT is unchanged. This also holds for the single-entry case; the pushed entry becomes the new head.
- Ordering: strictly FIFO. Writes to the same register leave the queue in acceptance order, so the bank ends up holding the last value.
- Forwarding (combinational):
  - Each valid entry, including the head currently presented, is compared with AR1 and with AR2.
  - The newest match wins, i.e. the match closest behind the write pointer.
  - AR==0 never hits.
  - The incoming WB_* request of the same cycle is not considered.
  - Readers select FWDx_DATA when FWDx_HIT=1, else the bank output.
- COUNT update: COUNT+1 on push only, COUNT-1 on pop only. It never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then idle -> COUNT=0, EMPTY=1, WB_READY=1, REG_WRITE=0, FWD1_HIT=0 for AR1=5.
- Push {5,0x11} at edge 1, HOLD=0 -> cycle 1: REG_WRITE=1, AW=5, DIN=0x11, FWD1_HIT=1 with AR1=5; cycle 2: EMPTY=1.
- HOLD=1, push {3,0xA},{3,0xB},{7,0xC},{9,0xD} -> COUNT=4, WB_READY=0; fifth push is not accepted; AR1=3 gives FWD1_DATA=0xB. Release HOLD -> AW sequence 3,3,7,9 over four cycles; bank reg 3 ends at 0xB.
- Full queue with HOLD=0 and WB_VALID held -> no push in the pop cycle; push accepted the next cycle; COUNT goes 4,3,4.
- Push {0,0xFF} -> handshake completes, COUNT stays 0, REG_WRITE never asserts; AR1=0 gives FWD1_HIT=0.
- Queue holds 3 entries, assert RST_N=0 for one edge while WB_VALID=1 -> COUNT=0, no REG_WRITE in the following cycle.
